// File: rtl/keypad_pkg.sv
// Shared constants and FSM state type for the 4x3 keypad emulator.
package keypad_pkg;
   localparam int NUM_ROWS = 4;
   localparam int NUM_COLS = 3;
   localparam int NUM_KEYS = 12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRESS = 2'd1,
      GAP   = 2'd2
   } state_t;
endpackage

// File: rtl/keypad_sweep_det.sv
// Flags the first cycle of each scanner sweep: the strobe arriving on the last row.
module keypad_sweep_det
   import keypad_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_ROWS-1:0] row,
   output logic                sweep
);
   localparam logic [NUM_ROWS-1:0] LAST_ROW = {1'b1, {(NUM_ROWS-1){1'b0}}};

   logic [NUM_ROWS-1:0] prev_row_q;
   logic [NUM_ROWS-1:0] prev_row_d;

   always_comb begin
      prev_row_d = row;
      sweep      = $onehot(row) && (row == LAST_ROW) && (prev_row_q != LAST_ROW);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_row_q <= '0;
      end else begin
         prev_row_q <= prev_row_d;
      end
   end
endmodule

// File: rtl/keypad_emulator.sv
// Emulates a 4x3 matrix keypad: holds one requested key pressed for a number of
// scanner sweeps, then leaves the pad released for a gap before the next request.
module keypad_emulator
   import keypad_pkg::*;
#(
   parameter int HOLD_SCANS = 4,
   parameter int GAP_SCANS  = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                key_valid,
   input  logic [3:0]          key_code,
   output logic                key_ready,
   input  logic [NUM_ROWS-1:0] row,
   output logic [NUM_COLS-1:0] column,
   output logic                busy,
   output logic                code_err
);
   localparam logic [3:0] MAX_CODE  = 4'(NUM_KEYS - 1);
   localparam logic [3:0] HOLD_LAST = 4'(HOLD_SCANS - 1);
   localparam logic [3:0] GAP_LAST  = 4'(GAP_SCANS - 1);

   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [NUM_ROWS-1:0] row_lat_q, row_lat_d;
   logic [NUM_COLS-1:0] col_lat_q, col_lat_d;
   logic                code_err_q, code_err_d;
   logic                sweep;

   keypad_sweep_det u_sweep_det (
      .clk   (clk),
      .rst   (rst),
      .row   (row),
      .sweep (sweep)
   );

   // Column return is purely combinational so the scanner sees it on the same strobe.
   always_comb begin
      key_ready = (state_q == IDLE);
      busy      = (state_q != IDLE);
      code_err  = code_err_q;
      column    = '0;
      if ((state_q == PRESS) && $onehot(row) && (row == row_lat_q)) begin
         column = col_lat_q;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      row_lat_d  = row_lat_q;
      col_lat_d  = col_lat_q;
      code_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (key_valid) begin
               if (key_code <= MAX_CODE) begin
                  row_lat_d = 4'b0001 << (key_code / 4'd3);
                  col_lat_d = 3'b001 << (key_code % 4'd3);
                  cnt_d     = '0;
                  state_d   = PRESS;
               end else begin
                  code_err_d = 1'b1;
               end
            end
         end
         PRESS: begin
            if (sweep) begin
               if (cnt_q == HOLD_LAST) begin
                  cnt_d   = '0;
                  state_d = GAP;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         GAP: begin
            if (sweep) begin
               if (cnt_q == GAP_LAST) begin
                  cnt_d   = '0;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         row_lat_q  <= '0;
         col_lat_q  <= '0;
         code_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         row_lat_q  <= row_lat_d;
         col_lat_q  <= col_lat_d;
         code_err_q <= code_err_d;
      end
   end
endmodule

// File: tb/tb_keypad_emulator.sv
// Randomized bench for keypad_emulator against a sweeps-remaining reference model.
module tb_keypad_emulator;
   localparam int HOLD = 4;
   localparam int GAP  = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       key_valid;
   logic [3:0] key_code;
   logic       key_ready;
   logic [3:0] row;
   logic [2:0] column;
   logic       busy;
   logic       code_err;

   int vec_count  = 0;
   int miss_count = 0;

   // Reference model: a request is remembered as a key position plus sweeps left to hold/release.
   int         m_press_left;
   int         m_gap_left;
   int         m_row_idx;
   int         m_col_idx;
   logic       m_err;
   logic [3:0] m_prev_row;
   int         scan_idx;

   keypad_emulator #(
      .HOLD_SCANS (HOLD),
      .GAP_SCANS  (GAP)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .key_valid (key_valid),
      .key_code  (key_code),
      .key_ready (key_ready),
      .row       (row),
      .column    (column),
      .busy      (busy),
      .code_err  (code_err)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vec_count++;
      if (obs !== exp) begin
         miss_count++;
         $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic modelReset();
      m_press_left = 0;
      m_gap_left   = 0;
      m_row_idx    = 0;
      m_col_idx    = 0;
      m_err        = 1'b0;
      m_prev_row   = 4'b0000;
   endtask

   task automatic modelStep(input logic v, input logic [3:0] code, input logic [3:0] r);
      logic sweep;
      sweep = (r == 4'b1000) && (m_prev_row != 4'b1000);
      m_err = 1'b0;
      if (m_press_left > 0) begin
         if (sweep) begin
            m_press_left--;
            if (m_press_left == 0) m_gap_left = GAP;
         end
      end else if (m_gap_left > 0) begin
         if (sweep) m_gap_left--;
      end else if (v) begin
         if (int'(code) < 12) begin
            m_row_idx    = int'(code) / 3;
            m_col_idx    = int'(code) % 3;
            m_press_left = HOLD;
         end else begin
            m_err = 1'b1;
         end
      end
      m_prev_row = r;
   endtask

   function automatic logic [2:0] expColumn(input logic [3:0] r);
      logic [3:0] key_row;
      key_row = 4'b0001 << m_row_idx;
      if ((m_press_left > 0) && (r == key_row)) return 3'b001 << m_col_idx;
      return 3'b000;
   endfunction

   task automatic applyStimulus(input logic v, input logic [3:0] code, input logic [3:0] r);
      logic idle;
      @(negedge clk);
      key_valid = v;
      key_code  = code;
      row       = r;
      #1;
      idle = (m_press_left == 0) && (m_gap_left == 0);
      checkOutput("column", 8'(column), 8'(expColumn(r)));
      checkOutput("key_ready", 8'(key_ready), 8'(idle));
      checkOutput("busy", 8'(busy), 8'(!idle));
      checkOutput("code_err", 8'(code_err), 8'(m_err));
      modelStep(v, code, r);
   endtask

   task automatic scan(input int n, input logic v, input logic [3:0] code, input int glitch_pct);
      logic [3:0] r;
      for (int i = 0; i < n; i++) begin
         r = 4'b0001 << scan_idx;
         if (int'($urandom_range(0, 99)) < glitch_pct) begin
            r = 4'($urandom_range(0, 15));
            if ($onehot(r)) r = 4'b1001;
         end
         applyStimulus(v, code, r);
         scan_idx = (scan_idx + 1) % 4;
      end
   endtask

   task automatic midPressReset();
      int guard;
      scan(1, 1'b1, 4'd5, 0);
      guard = 0;
      while ((m_press_left != HOLD - 1) && (guard < 200)) begin
         scan(1, 1'b0, 4'd0, 0);
         guard++;
      end
      checkOutput("reach_second_sweep", 8'(m_press_left == HOLD - 1), 8'd1);
      applyStimulus(1'b0, 4'd0, 4'b0001 << m_row_idx);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rst_column", 8'(column), 8'd0);
      checkOutput("rst_busy", 8'(busy), 8'd0);
      checkOutput("rst_ready", 8'(key_ready), 8'd1);
      @(negedge clk);
      key_valid = 1'b0;
      row       = 4'b0000;
      #1;
      checkOutput("rst_held_column", 8'(column), 8'd0);
      rst = 1'b0;
      modelReset();
      scan_idx = 0;
   endtask

   initial begin
      rst       = 1'b1;
      key_valid = 1'b0;
      key_code  = 4'd0;
      row       = 4'b0000;
      scan_idx  = 0;
      modelReset();
      #1;
      checkOutput("reset_column", 8'(column), 8'd0);
      checkOutput("reset_busy", 8'(busy), 8'd0);
      checkOutput("reset_ready", 8'(key_ready), 8'd1);
      checkOutput("reset_code_err", 8'(code_err), 8'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      $display("[TB] directed: code 4, code 11, code 13");
      scan(1, 1'b1, 4'd4, 0);
      scan(40, 1'b0, 4'd0, 0);
      scan(1, 1'b1, 4'd11, 0);
      scan(40, 1'b0, 4'd0, 0);
      scan(1, 1'b1, 4'd13, 0);
      scan(4, 1'b0, 4'd0, 0);

      $display("[TB] directed: code 0 held during code 7 press");
      scan(1, 1'b1, 4'd7, 0);
      scan(60, 1'b1, 4'd0, 0);
      scan(40, 1'b0, 4'd0, 0);

      $display("[TB] directed: non-one-hot rows during press");
      scan(1, 1'b1, 4'd9, 0);
      scan(80, 1'b0, 4'd0, 30);

      $display("[TB] directed: reset in second sweep of press");
      midPressReset();
      scan(1, 1'b1, 4'd2, 0);
      scan(40, 1'b0, 4'd0, 0);

      $display("[TB] random traffic");
      for (int i = 0; i < 1500; i++) begin
         scan(1, ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), 5);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
      $finish;
   end
endmodule

// File: doc/keypad_emulator.md
KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

Interface
REQ-001 The module SHALL have the parameter HOLD_SCANS, default 4, giving the number of full row sweeps a key is held pressed (legal range 1..15).
REQ-002 The module SHALL have the parameter GAP_SCANS, default 2, giving the number of full row sweeps of released keypad after each press (legal range 1..15).
REQ-003 The module SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have the port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The module SHALL have the port key_valid, input, 1 bit: a key request is present.
REQ-006 The module SHALL have the port key_code, input, 4 bits: key index, where 0..11 is valid, row = code/3 and col = code%3.
REQ-007 The module SHALL have the port key_ready, output, 1 bit: the module accepts a request this cycle.
REQ-008 The module SHALL have the port row, input, 4 bits: one-hot row strobe driven by the scanner.
REQ-009 The module SHALL have the port column, output, 3 bits: one-hot column return to the scanner.
REQ-010 The module SHALL have the port busy, output, 1 bit: a press or gap is in progress.
REQ-011 The module SHALL have the port code_err, output, 1 bit: one-cycle pulse when an invalid code is offered.

Function
REQ-012 The FSM SHALL have three states: IDLE, PRESS and GAP.
REQ-013 A handshake SHALL occur on a rising edge with key_valid=1 and key_ready=1; key_ready SHALL equal 1 only in IDLE.
REQ-014 On a handshake with key_code<=11, the module SHALL latch the row one-hot (1<<(code/3)) and column one-hot (1<<(code%3)), clear the sweep counter, and enter PRESS.
REQ-015 On a handshake with key_code>=12, the module SHALL pulse code_err high for exactly the following cycle and stay in IDLE.
REQ-016 A sweep event SHALL be the cycle in which row==4'b1000 and the registered previous row!=4'b1000.
REQ-017 In PRESS, column SHALL equal the latched column one-hot whenever row equals the latched row one-hot, and 3'b000 otherwise; this path SHALL be combinational, with zero latency from row.
REQ-018 In IDLE and GAP, column SHALL equal 3'b000 regardless of row.
REQ-019 If row is not one-hot (zero bits or more than one bit set), column SHALL equal 3'b000 and no sweep event SHALL be counted.
REQ-020 In PRESS, every sweep event SHALL increment the counter; on the HOLD_SCANS-th event the module SHALL clear the counter and enter GAP.
REQ-021 In GAP, on the GAP_SCANS-th sweep event the module SHALL enter IDLE, with key_ready=1 from the next cycle.
REQ-022 busy SHALL equal 1 exactly when the state is not IDLE.
REQ-023 The sweep counter SHALL be 4 bits wide and SHALL never wrap, because the state changes on reaching its terminal count.
REQ-024 A key_valid arriving while busy SHALL be held off (key_ready=0) and SHALL NOT be dropped or latched until IDLE.

Reset
REQ-025 On rst=1, asynchronously: state=IDLE, counter=0, latched row/column=0, previous row=0, code_err=0; outputs SHALL be column=3'b000, busy=0, key_ready=1 while rst is high.
REQ-026 A reset asserted mid-PRESS SHALL force column to 3'b000 immediately, without waiting for a clock edge.

Structure
REQ-027 The shared package keypad_pkg SHALL hold NUM_ROWS=4, NUM_COLS=3, NUM_KEYS=12 and the FSM state enum.
REQ-028 Sweep detection (row[3] rising edge with the one-hot check) SHALL be the sub-module keypad_sweep_det; all other logic SHALL be in keypad_emulator.

Verification
REQ-029 Scenario 1: with defaults, offer code 4 while the scanner cycles rows 0001->0010->0100->1000 -> column=3'b010 only while row=0010, for exactly 4 sweeps; then 2 sweeps of 000; then key_ready=1.
REQ-030 Scenario 2: offer code 11 -> column=3'b100 only while row=1000; busy=1 from the cycle after the handshake until the GAP exit.
REQ-031 Scenario 3: offer code 13 -> code_err=1 for one cycle, busy stays 0, column stays 000, key_ready stays 1.
REQ-032 Scenario 4: hold key_valid=1 with code 0 during a press of code 7 -> code 0 accepted only in the first IDLE cycle after the GAP; no overlap on column.
REQ-033 Scenario 5: drive row=4'b0000 and 4'b1001 during PRESS -> column=000 and the sweep count unchanged.
REQ-034 Scenario 6: assert rst in the second sweep of PRESS -> column=000 and busy=0 asynchronously; after release, the next code is accepted normally.
